// File: rtl/chip8_program_loader.sv
// chip8_program_loader: zero-fills the program area, streams a length-prefixed payload into CPU memory port A, verifies an 8-bit sum
// Ports: clk, reset (sync, active-high); start pulse; in_valid/in_data/in_ready byte stream;
// mem_en/mem_write/mem_addr/mem_in drive CPU memory port A; cpu_halt, busy, done, error status.
module chip8_program_loader #(
  parameter logic [11:0] LOAD_BASE = 12'h200,
  parameter int MAX_LEN = 3584
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_in,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, CLEAR, DATA, CHECK, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [11:0] len, ptr, n;
  logic [7:0] sum;
  logic fmt_err, acc, wr;
  always_comb begin
    acc = in_valid && in_ready;
    n = {len[11:8], in_data};
    wr = (state == CLEAR) || (state == DATA && acc);
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? LEN_HI : state;
      LEN_HI: state_n = acc ? LEN_LO : state;
      LEN_LO: state_n = !acc ? state : (n == 12'd0 || 32'(n) > MAX_LEN || fmt_err) ? ERROR : CLEAR;
      CLEAR: state_n = ptr == 12'hFFF ? DATA : CLEAR;
      DATA: state_n = (acc && ptr == LOAD_BASE + len - 12'd1) ? CHECK : DATA;
      CHECK: state_n = !acc ? state : in_data == sum ? DONE : ERROR;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      cpu_halt <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      mem_en <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= 12'd0;
      mem_in <= 8'd0;
      len <= 12'd0;
      ptr <= 12'd0;
      sum <= 8'd0;
      fmt_err <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n inside {LEN_HI, LEN_LO, DATA, CHECK};
      busy <= state_n inside {LEN_HI, LEN_LO, CLEAR, DATA, CHECK};
      cpu_halt <= !(state_n inside {IDLE, DONE});
      done <= state_n == DONE;
      error <= state_n == ERROR;
      mem_en <= wr;
      mem_write <= wr;
      if (wr) begin
        mem_addr <= ptr;
        mem_in <= state == CLEAR ? 8'h00 : in_data;
      end
      if (state_n == LEN_HI && state != LEN_HI) begin
        len <= 12'd0;
        sum <= 8'd0;
        fmt_err <= 1'b0;
      end
      if (state == LEN_HI && acc) begin
        fmt_err <= |in_data[7:4];
        len[11:8] <= in_data[3:0];
      end
      if (state == LEN_LO && acc) begin
        len[7:0] <= in_data;
        ptr <= LOAD_BASE;
      end
      // ptr walks the clear range, then rewinds to LOAD_BASE for the payload.
      if (state == CLEAR) ptr <= ptr == 12'hFFF ? LOAD_BASE : ptr + 12'd1;
      if (state == DATA && acc) begin
        ptr <= ptr + 12'd1;
        sum <= sum + in_data;
      end
    end
  end
endmodule

// File: tb/tb_chip8_program_loader.sv
// tb_chip8_program_loader: scoreboarded random and directed loads against a frame-level model
module tb_chip8_program_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, mem_en, mem_write, cpu_halt, busy, done, error;
  logic [11:0] mem_addr;
  logic [7:0] mem_in;
  typedef struct packed {logic [11:0] a; logic [7:0] d;} wr_t;
  wr_t sb[$];
  logic [7:0] q[$];
  int total = 0, bad = 0;

  chip8_program_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_in(mem_in), .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout actual=0 required=1");
        $fatal(1, "in_ready never asserted");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_status", {busy, done, error, cpu_halt}, 4'b1001);
  endtask

  task automatic push_image(input logic [7:0] pl[$]);
    for (int a = 'h200; a < 4096; a++) sb.push_back({12'(a), 8'h00});
    foreach (pl[i]) sb.push_back({12'(12'h200 + i), pl[i]});
  endtask

  task automatic frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] pl[$],
                       input bit bad_sum, input bit gap, input bit poke);
    int n = {hi[3:0], lo};
    int s = 0;
    bit ok = hi[7:4] == 4'd0 && n > 0 && n <= 3584;
    logic [7:0] sum;
    foreach (pl[i]) s += pl[i];
    sum = 8'(s % 256) ^ (bad_sum ? 8'h01 : 8'h00);
    do_start();
    if (ok) push_image(pl);
    send(hi, 1'b0);
    send(lo, 1'b0);
    if (ok) begin
      in_valid = 1'b1;
      in_data = 8'hEE;
      repeat (3) @(negedge clk);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("clear_in_ready", {in_ready, busy}, 2'b01);
      in_valid = 1'b0;
      foreach (pl[i]) send(pl[i], gap);
      send(sum, gap);
    end
    @(negedge clk);
    #1;
    chk("writes_drained", sb.size(), 0);
    chk("final_status", {done, error, cpu_halt, busy}, (ok && !bad_sum) ? 4'b1000 : 4'b0110);
    sb.delete();
  endtask

  initial begin
    wr_t e;
    fork
      forever begin
        @(negedge clk);
        if (mem_en || mem_write) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_in);
          end else begin
            e = sb.pop_front();
            chk("write", {mem_en, mem_write, mem_addr, mem_in}, {2'b11, e});
          end
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk("reset_state", {in_ready, mem_en, mem_write, cpu_halt, busy, done, error, mem_addr, mem_in}, 0);
    reset = 1'b0;
    q = {8'hA1, 8'hB2, 8'hC3};
    frame(8'h00, 8'h03, q, 1'b0, 1'b0, 1'b0);
    frame(8'h00, 8'h03, q, 1'b1, 1'b0, 1'b0);
    q.delete();
    frame(8'h00, 8'h00, q, 1'b0, 1'b0, 1'b0);
    frame(8'h0E, 8'h01, q, 1'b0, 1'b0, 1'b0);
    frame(8'h10, 8'h03, q, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3584; i++) q.push_back(8'($urandom));
    frame(8'h0E, 8'h00, q, 1'b0, 1'b0, 1'b0);
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_start();
    push_image(q);
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    send(q[0], 1'b0);
    send(q[1], 1'b0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_data", {in_ready, mem_en, mem_write, cpu_halt, busy, done, error, mem_addr, mem_in}, 0);
    chk("reset_pending_writes", sb.size(), 3);
    sb.delete();
    reset = 1'b0;
    q = {8'hA1, 8'hB2, 8'hC3};
    frame(8'h00, 8'h03, q, 1'b0, 1'b0, 1'b0);
    frame(8'h00, 8'h03, q, 1'b0, 1'b1, 1'b1);
    frame(8'h00, 8'h03, q, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 6);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      frame(8'h00, 8'(n), q, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
